// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan controller.
package seg7_pkg;

    // Active-low segment patterns, bit order {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;

    // Digit index width; a single-digit display still needs one bit
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Nibble to segment pattern; codes 10-15 go dark outside hex mode
    function automatic logic [6:0] nib_to_seg(input logic [3:0] code, input logic hex_mode);
        logic [6:0] pat;
        case (code)
            4'h0:    pat = SEG_0;
            4'h1:    pat = SEG_1;
            4'h2:    pat = SEG_2;
            4'h3:    pat = SEG_3;
            4'h4:    pat = SEG_4;
            4'h5:    pat = SEG_5;
            4'h6:    pat = SEG_6;
            4'h7:    pat = SEG_7;
            4'h8:    pat = SEG_8;
            4'h9:    pat = SEG_9;
            4'hA:    pat = SEG_A;
            4'hB:    pat = SEG_B;
            4'hC:    pat = SEG_C;
            4'hD:    pat = SEG_D;
            4'hE:    pat = SEG_E;
            default: pat = SEG_F;
        endcase
        if (!hex_mode && (code > 4'd9)) begin
            pat = SEG_BLANK;
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble-to-segment decoder (active-low outputs).
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_mode_i,
    output logic [6:0] seg_o
);

    // Pure table lookup shared with the package helper
    always_comb begin
        seg_o = nib_to_seg(code_i, hex_mode_i);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment driver with tear-free
// frame-boundary commit of loaded data.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to add the lzb_en input that
// darkens leading zero digits (digit 0 always stays lit).
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter  int unsigned NUM_DIGITS  = 8,
    parameter  int unsigned REFRESH_DIV = 100000,
    localparam int unsigned IDX_W       = idx_w(NUM_DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    hex_mode,
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    input  logic                    lzb_en,
`endif
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start,
    output logic                    pending
);

    localparam int unsigned          CNT_W    = 32'($clog2(REFRESH_DIV));
    localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam int unsigned          DATA_W   = 4 * NUM_DIGITS;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  tick, wrap;

    logic [DATA_W-1:0]     sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0] sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0] sh_blank_q, sh_blank_d;
    logic [DATA_W-1:0]     disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
    logic                  pending_q, pending_d;
    logic                  fs_q, fs_d;

    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic [3:0]            nib;
    logic                  dig_dp, dig_blank, dig_lz;
    logic [6:0]            dec_seg;
    logic                  blank;
    logic [NUM_DIGITS-1:0] lz_mask;

    // Prescaler and digit index advance; everything holds while disabled
    always_comb begin
        tick  = en && (cnt_q == CNT_MAX);
        wrap  = tick && (idx_q == IDX_LAST);
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow capture and frame-boundary commit; a load on the commit tick bypasses the shadow
    always_comb begin
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        pending_d    = pending_q;
        fs_d         = wrap;
        if (load) begin
            sh_data_d  = data_in;
            sh_dp_d    = dp_in;
            sh_blank_d = blank_in;
            pending_d  = 1'b1;
        end
        if (wrap) begin
            disp_data_d  = load ? data_in  : sh_data_q;
            disp_dp_d    = load ? dp_in    : sh_dp_q;
            disp_blank_d = load ? blank_in : sh_blank_q;
            pending_d    = 1'b0;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_above;

    // Mark zero digits that sit above the most-significant nonzero digit
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_data_d[4*i +: 4] == 4'h0);
            lz_mask[i] = lzb_en & zero_above;
        end
    end
`else
    assign lz_mask = '0;
`endif

    // Select the digit that will be driven after this edge and build the anode vector
    always_comb begin
        nib       = '0;
        dig_dp    = 1'b0;
        dig_blank = 1'b0;
        dig_lz    = 1'b0;
        an_d      = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                nib       = disp_data_d[4*i +: 4];
                dig_dp    = disp_dp_d[i];
                dig_blank = disp_blank_d[i];
                dig_lz    = lz_mask[i];
                an_d[i]   = ~en;
            end
        end
    end

    seg7_hex_decoder u_dec (
        .code_i     (nib),
        .hex_mode_i (hex_mode),
        .seg_o      (dec_seg)
    );

    // Blanked digits darken segments and dp but keep their anode slot
    always_comb begin
        blank = dig_blank | dig_lz | (dec_seg == SEG_BLANK);
        seg_d = blank ? SEG_BLANK : dec_seg;
        dp_d  = blank | ~dig_dp;
    end

    // State and pin registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            pending_q    <= 1'b0;
            fs_q         <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            pending_q    <= pending_d;
            fs_q         <= fs_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign digit_idx   = idx_q;
    assign frame_start = fs_q;
    assign pending     = pending_q;

endmodule
